// File: rtl/vram_rect_fill.sv
// Rectangle-fill writer for the 256x256 RGB VRAM write port.
// Emits one clipped pixel write per clock in row-major order.
module vram_rect_fill #(
  parameter int COORD_W = 8,
  parameter int COLOR_W = 8
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iCmd_valid,
  output logic               oCmd_ready,
  input  logic [COORD_W-1:0] iCmd_x0,
  input  logic [COORD_W-1:0] iCmd_y0,
  input  logic [COORD_W:0]   iCmd_w,
  input  logic [COORD_W:0]   iCmd_h,
  input  logic [COLOR_W-1:0] iCmd_r,
  input  logic [COLOR_W-1:0] iCmd_g,
  input  logic [COLOR_W-1:0] iCmd_b,
  input  logic               iAbort,
  output logic [COORD_W-1:0] oWrite_x,
  output logic [COORD_W-1:0] oWrite_y,
  output logic [COLOR_W-1:0] oWrite_r,
  output logic [COLOR_W-1:0] oWrite_g,
  output logic [COLOR_W-1:0] oWrite_b,
  output logic               oWrite_en,
  output logic               oBusy,
  output logic               oDone
);

  // state | meaning
  // IDLE  | waiting for a command, oCmd_ready high
  // FILL  | one pixel write per cycle
  // DONE  | single-cycle oDone pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [COORD_W+1:0] AREA  = {2'b01, {COORD_W{1'b0}}};
  localparam logic [COORD_W-1:0] ONE_C = 1;

  state_t             r_state, w_state_nxt;
  logic [COORD_W-1:0] r_x0, w_x0_nxt;
  logic [COORD_W-1:0] r_xend, w_xend_nxt;
  logic [COORD_W-1:0] r_yend, w_yend_nxt;
  logic [COORD_W-1:0] r_wx, w_wx_nxt;
  logic [COORD_W-1:0] r_wy, w_wy_nxt;
  logic [COLOR_W-1:0] r_r, w_r_nxt;
  logic [COLOR_W-1:0] r_g, w_g_nxt;
  logic [COLOR_W-1:0] r_b, w_b_nxt;
  logic               r_en, w_en_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;

  logic [COORD_W+1:0] w_sum_x, w_sum_y, w_eff_w, w_eff_h;
  logic [COORD_W-1:0] w_xend_new, w_yend_new;
  logic               w_empty, w_last_x, w_last_y;

  // Clip in COORD_W+2 bits so x0+w never overflows before the compare.
  assign w_sum_x = {2'b00, iCmd_x0} + {1'b0, iCmd_w};
  assign w_sum_y = {2'b00, iCmd_y0} + {1'b0, iCmd_h};
  assign w_eff_w = (w_sum_x > AREA) ? (AREA - {2'b00, iCmd_x0}) : {1'b0, iCmd_w};
  assign w_eff_h = (w_sum_y > AREA) ? (AREA - {2'b00, iCmd_y0}) : {1'b0, iCmd_h};
  assign w_empty = (w_eff_w == '0) || (w_eff_h == '0);

  // Modulo arithmetic is safe: a full-width span from 0 ends at all-ones.
  assign w_xend_new = iCmd_x0 + w_eff_w[COORD_W-1:0] - ONE_C;
  assign w_yend_new = iCmd_y0 + w_eff_h[COORD_W-1:0] - ONE_C;

  assign w_last_x = (r_wx == r_xend);
  assign w_last_y = (r_wy == r_yend);

  assign oCmd_ready = (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_x0_nxt    = r_x0;
    w_xend_nxt  = r_xend;
    w_yend_nxt  = r_yend;
    w_wx_nxt    = r_wx;
    w_wy_nxt    = r_wy;
    w_r_nxt     = r_r;
    w_g_nxt     = r_g;
    w_b_nxt     = r_b;
    w_en_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iCmd_valid) begin
          w_x0_nxt   = iCmd_x0;
          w_xend_nxt = w_xend_new;
          w_yend_nxt = w_yend_new;
          if (w_empty) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_FILL;
            w_wx_nxt    = iCmd_x0;
            w_wy_nxt    = iCmd_y0;
            w_r_nxt     = iCmd_r;
            w_g_nxt     = iCmd_g;
            w_b_nxt     = iCmd_b;
            w_en_nxt    = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (iAbort || (w_last_x && w_last_y)) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end else if (w_last_x) begin
          w_wx_nxt = r_x0;
          w_wy_nxt = r_wy + ONE_C;
          w_en_nxt = 1'b1;
        end else begin
          w_wx_nxt = r_wx + ONE_C;
          w_en_nxt = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_x0    <= '0;
      r_xend  <= '0;
      r_yend  <= '0;
      r_wx    <= '0;
      r_wy    <= '0;
      r_r     <= '0;
      r_g     <= '0;
      r_b     <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x0    <= w_x0_nxt;
      r_xend  <= w_xend_nxt;
      r_yend  <= w_yend_nxt;
      r_wx    <= w_wx_nxt;
      r_wy    <= w_wy_nxt;
      r_r     <= w_r_nxt;
      r_g     <= w_g_nxt;
      r_b     <= w_b_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign oWrite_x  = r_wx;
  assign oWrite_y  = r_wy;
  assign oWrite_r  = r_r;
  assign oWrite_g  = r_g;
  assign oWrite_b  = r_b;
  assign oWrite_en = r_en;
  assign oBusy     = r_busy;
  assign oDone     = r_done;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Bench for vram_rect_fill: table vectors, random commands against a
// row-major pixel-list model, plus abort/hold and mid-fill reset sequences.
module tb_vram_rect_fill;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b1;
  logic       iCmd_valid = 1'b0;
  logic       oCmd_ready;
  logic [7:0] iCmd_x0 = '0, iCmd_y0 = '0;
  logic [8:0] iCmd_w = '0, iCmd_h = '0;
  logic [7:0] iCmd_r = '0, iCmd_g = '0, iCmd_b = '0;
  logic       iAbort = 1'b0;
  logic [7:0] oWrite_x, oWrite_y, oWrite_r, oWrite_g, oWrite_b;
  logic       oWrite_en, oBusy, oDone;

  vram_rect_fill #(.COORD_W(8), .COLOR_W(8)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N),
    .iCmd_valid(iCmd_valid), .oCmd_ready(oCmd_ready),
    .iCmd_x0(iCmd_x0), .iCmd_y0(iCmd_y0), .iCmd_w(iCmd_w), .iCmd_h(iCmd_h),
    .iCmd_r(iCmd_r), .iCmd_g(iCmd_g), .iCmd_b(iCmd_b), .iAbort(iAbort),
    .oWrite_x(oWrite_x), .oWrite_y(oWrite_y),
    .oWrite_r(oWrite_r), .oWrite_g(oWrite_g), .oWrite_b(oWrite_b),
    .oWrite_en(oWrite_en), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {int x0; int y0; int w; int h; int r; int g; int b;} cmd_t;
  typedef struct {cmd_t c; int abort_at; int exp_writes; int exp_lx; int exp_ly;} vec_t;

  int n_checks = 0;
  int n_errors = 0;
  // Last pixel the model believes was written (held on the port while idle).
  int m_lx = 0, m_ly = 0, m_r = 0, m_g = 0, m_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic cmd_t mkc(int x0, int y0, int w, int h, int r, int g, int b);
    cmd_t c;
    c.x0 = x0; c.y0 = y0; c.w = w; c.h = h; c.r = r; c.g = g; c.b = b;
    return c;
  endfunction

  function automatic vec_t mkv(cmd_t c, int ab, int ew, int lx, int ly);
    vec_t v;
    v.c = c; v.abort_at = ab; v.exp_writes = ew; v.exp_lx = lx; v.exp_ly = ly;
    return v;
  endfunction

  task automatic drive_cmd(input cmd_t c);
    iCmd_x0 = 8'(c.x0); iCmd_y0 = 8'(c.y0);
    iCmd_w  = 9'(c.w);  iCmd_h  = 9'(c.h);
    iCmd_r  = 8'(c.r);  iCmd_g  = 8'(c.g);  iCmd_b = 8'(c.b);
  endtask

  // Called just after a falling edge. Presents c, waits for acceptance and
  // checks every cycle through the return of ready.
  task automatic run_cmd(input cmd_t c, input int abort_at, input bit hold_next,
                         input cmd_t nxt, output int writes, output int lx, output int ly);
    int ew, eh, n, nw, bad, busy_bad, first_done, n_done, first_rdy, k, i;
    ew = (c.w < 256 - c.x0) ? c.w : 256 - c.x0;
    eh = (c.h < 256 - c.y0) ? c.h : 256 - c.y0;
    n  = ew * eh;
    nw = (abort_at >= 1 && abort_at < n) ? abort_at : n;
    writes = 0; bad = 0; busy_bad = 0; first_done = 0; n_done = 0; first_rdy = 0;
    drive_cmd(c);
    iCmd_valid = 1'b1;
    i = 0;
    while (!oCmd_ready && i < 100) begin
      @(negedge iCLK);
      i++;
    end
    if (!oCmd_ready) begin
      chk("accept_timeout", 0, 1);
      iCmd_valid = 1'b0;
      lx = 0; ly = 0;
      return;
    end
    if (nw > 0) begin
      k = nw - 1;
      m_lx = c.x0 + k % ew; m_ly = c.y0 + k / ew;
      m_r = c.r; m_g = c.g; m_b = c.b;
    end
    for (int cyc = 1; cyc <= nw + 2; cyc++) begin
      @(negedge iCLK);
      if (oWrite_en) writes++;
      if (cyc <= nw) begin
        k = cyc - 1;
        if (!oWrite_en || oWrite_x != c.x0 + k % ew || oWrite_y != c.y0 + k / ew ||
            oWrite_r != c.r || oWrite_g != c.g || oWrite_b != c.b) bad++;
      end else if (oWrite_en) bad++;
      if (cyc == nw + 1 && (oWrite_x != m_lx || oWrite_y != m_ly ||
          oWrite_r != m_r || oWrite_g != m_g || oWrite_b != m_b)) bad++;
      if (oDone) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
      if (oCmd_ready && first_rdy == 0) first_rdy = cyc;
      if (oBusy != (cyc <= nw + 1)) busy_bad++;
      if (cyc == 1) begin
        if (hold_next) drive_cmd(nxt);
        else begin
          iCmd_valid = 1'b0;
          iCmd_x0 = 8'($urandom); iCmd_y0 = 8'($urandom);
          iCmd_w  = 9'($urandom); iCmd_h  = 9'($urandom);
          iCmd_r  = 8'($urandom); iCmd_g  = 8'($urandom); iCmd_b = 8'($urandom);
        end
      end
      iAbort = (cyc == abort_at);
    end
    iAbort = 1'b0;
    chk("writes", writes, nw);
    chk("pixel_bad", bad, 0);
    chk("done_cycle", first_done, nw + 1);
    chk("done_count", n_done, 1);
    chk("ready_cycle", first_rdy, nw + 2);
    chk("busy_bad", busy_bad, 0);
    lx = oWrite_x; ly = oWrite_y;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[10];
    cmd_t c, c2;
    int wr, lx, ly, ab, ew, eh, n, cnt_en, cnt_done;

    tbl[0] = mkv(mkc(10, 20, 3, 2, 8'hFF, 8'h00, 8'h80), 0, 6, 12, 21);
    tbl[1] = mkv(mkc(254, 255, 5, 4, 1, 2, 3), 0, 2, 255, 255);
    tbl[2] = mkv(mkc(5, 5, 0, 7, 9, 9, 9), 0, 0, 255, 255);
    tbl[3] = mkv(mkc(0, 0, 256, 256, 8'h12, 8'h34, 8'h56), 0, 65536, 255, 255);
    tbl[4] = mkv(mkc(100, 50, 4, 4, 7, 8, 9), 3, 3, 102, 50);
    tbl[5] = mkv(mkc(250, 10, 6, 1, 1, 1, 1), 6, 6, 255, 10);
    tbl[6] = mkv(mkc(1, 1, 2, 1, 4, 5, 6), 3, 2, 2, 1);
    tbl[7] = mkv(mkc(0, 255, 1, 256, 1, 2, 3), 0, 1, 0, 255);
    tbl[8] = mkv(mkc(200, 3, 256, 0, 5, 5, 5), 0, 0, 0, 255);
    tbl[9] = mkv(mkc(255, 0, 256, 256, 77, 88, 99), 0, 256, 255, 255);

    #2 iRST_N = 1'b0;
    #1;
    chk("rst_ready", oCmd_ready, 1);
    chk("rst_xy", {oWrite_x, oWrite_y}, 0);
    chk("rst_rgb", {oWrite_r, oWrite_g, oWrite_b}, 0);
    chk("rst_flags", {oWrite_en, oBusy, oDone}, 0);
    @(negedge iCLK);
    #3 iRST_N = 1'b1;
    @(negedge iCLK);
    chk("idle_ready", oCmd_ready, 1);

    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].c, tbl[i].abort_at, 1'b0, tbl[i].c, wr, lx, ly);
      chk("tbl_writes", wr, tbl[i].exp_writes);
      chk("tbl_last_x", lx, tbl[i].exp_lx);
      chk("tbl_last_y", ly, tbl[i].exp_ly);
    end

    // Abort in the 3rd fill cycle while a second command waits, held valid.
    c  = mkc(100, 50, 4, 4, 8'h11, 8'h22, 8'h33);
    c2 = mkc(5, 6, 2, 2, 8'hAA, 8'hBB, 8'hCC);
    run_cmd(c, 3, 1'b1, c2, wr, lx, ly);
    chk("hold_a_writes", wr, 3);
    run_cmd(c2, 0, 1'b0, c2, wr, lx, ly);
    chk("hold_b_last_x", lx, 6);
    chk("hold_b_last_y", ly, 7);

    // Asynchronous reset mid-fill.
    drive_cmd(mkc(30, 40, 10, 10, 1, 2, 3));
    iCmd_valid = 1'b1;
    @(negedge iCLK);
    iCmd_valid = 1'b0;
    repeat (4) @(negedge iCLK);
    #2 iRST_N = 1'b0;
    #1;
    chk("midrst_ready", oCmd_ready, 1);
    chk("midrst_xy", {oWrite_x, oWrite_y}, 0);
    chk("midrst_rgb", {oWrite_r, oWrite_g, oWrite_b}, 0);
    chk("midrst_flags", {oWrite_en, oBusy, oDone}, 0);
    #5 iRST_N = 1'b1;
    cnt_en = 0; cnt_done = 0;
    repeat (20) begin
      @(negedge iCLK);
      if (oWrite_en) cnt_en++;
      if (oDone) cnt_done++;
    end
    chk("postrst_writes", cnt_en, 0);
    chk("postrst_done", cnt_done, 0);
    chk("postrst_ready", oCmd_ready, 1);
    m_lx = 0; m_ly = 0; m_r = 0; m_g = 0; m_b = 0;
    run_cmd(mkc(9, 9, 3, 0, 1, 1, 1), 0, 1'b0, c2, wr, lx, ly);
    chk("postrst_hold_x", lx, 0);

    // Random commands, biased toward the clipping edges.
    for (int i = 0; i < 25; i++) begin
      c.x0 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(240, 255);
      c.y0 = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255) : $urandom_range(240, 255);
      if ($urandom_range(0, 7) == 0) begin
        c.w = $urandom_range(200, 256);
        c.h = $urandom_range(0, 2);
      end else begin
        c.w = $urandom_range(0, 12);
        c.h = $urandom_range(0, 12);
      end
      c.r = $urandom_range(0, 255); c.g = $urandom_range(0, 255); c.b = $urandom_range(0, 255);
      ew = (c.w < 256 - c.x0) ? c.w : 256 - c.x0;
      eh = (c.h < 256 - c.y0) ? c.h : 256 - c.y0;
      n  = ew * eh;
      ab = (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n + 1) : 0;
      run_cmd(c, ab, 1'b0, c, wr, lx, ly);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
